// File: rtl/retire_pair_scheduler.sv
// retire_pair_scheduler: lockstep scheduler for a two-core harness.
// It gates each core's clock enable so that retirements complete in pairs.
// It stops fetch at a program end address or after an instruction budget,
// drains in-flight work, and then reports completion. It flags a timeout when
// one core waits too long for its partner to retire.
// Optional: define RETIRE_SCHED_ASSERT_EN to embed invariant assertions.
module retire_pair_scheduler #(
    parameter int unsigned MAX_INSTR    = 16,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             retire_1_i,
    input  logic             retire_2_i,
    input  logic             fetch_1_i,
    input  logic             fetch_2_i,
    input  logic [31:0]      instr_addr_1_i,
    input  logic [31:0]      instr_addr_2_i,
    input  logic [31:0]      end_addr_i,
    output logic             run_1_o,
    output logic             run_2_o,
    output logic             enable_1_o,
    output logic             enable_2_o,
    output logic             pair_retire_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic             finished_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_INSTR);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             hold_1_q, hold_1_d, hold_2_q, hold_2_d;
    logic             stop_q, stop_d;
    logic             pair_q, pair_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             timeout_q, timeout_d;
    logic             finished_q, finished_d;

    logic active, q1, q2, pair_done, any_hold, stop_cond, timeout_hit;

    // A core is clocked only while running and not waiting for its partner.
    assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign run_1_o    = active && !hold_1_q;
    assign run_2_o    = active && !hold_2_q;
    assign enable_1_o = (state_q == S_RUN) && !stop_q;
    assign enable_2_o = (state_q == S_RUN) && !stop_q;

    // A retire from a held core is ignored because its clock is gated off.
    assign q1        = retire_1_i && run_1_o;
    assign q2        = retire_2_i && run_2_o;
    assign any_hold  = hold_1_q || hold_2_q;
    assign pair_done = (q1 && q2) || (hold_1_q && q2) || (hold_2_q && q1);
    assign stop_cond = (cnt_q >= MAX_C)
                    || (fetch_1_i && (instr_addr_1_i >= end_addr_i))
                    || (fetch_2_i && (instr_addr_2_i >= end_addr_i));
    assign timeout_hit = active && any_hold && !pair_done && (tmo_q >= TMO_LAST);

    assign pair_retire_o = pair_q;
    assign retire_cnt_o  = cnt_q;
    assign finished_o    = finished_q;
    assign timeout_o     = timeout_q;

    // Next-state logic: pairing, stop, drain, timeout, and FSM transitions.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch.
        state_d    = state_q;
        hold_1_d   = hold_1_q;
        hold_2_d   = hold_2_q;
        stop_d     = stop_q;
        pair_d     = 1'b0;
        cnt_d      = cnt_q;
        drain_d    = '0;
        tmo_d      = tmo_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN, S_DRAIN: begin
                pair_d = pair_done;
                if (pair_done) begin
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
                    tmo_d = '0;
                end else if (any_hold) begin
                    tmo_d = tmo_q + CNT_ONE;
                end

                if (hold_1_q && q2)                    hold_1_d = 1'b0;
                else if (q1 && !q2 && !hold_2_q)       hold_1_d = 1'b1;
                if (hold_2_q && q1)                    hold_2_d = 1'b0;
                else if (q2 && !q1 && !hold_1_q)       hold_2_d = 1'b1;

                if (state_q == S_RUN && stop_cond) stop_d = 1'b1;

                if (state_q == S_DRAIN) begin
                    drain_d = (drain_q < DRAIN_LAST) ? drain_q + CNT_ONE : drain_q;
                end

                if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else if (state_q == S_RUN && stop_q) begin
                    state_d = S_DRAIN;
                end else if (state_q == S_DRAIN && drain_q >= DRAIN_LAST && !any_hold) begin
                    state_d = S_DONE;
                end
            end
            default: ;  // DONE is terminal until reset
        endcase

        finished_d = finished_q || (state_d == S_DONE);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            hold_1_q   <= 1'b0;
            hold_2_q   <= 1'b0;
            stop_q     <= 1'b0;
            pair_q     <= 1'b0;
            cnt_q      <= '0;
            drain_q    <= '0;
            tmo_q      <= '0;
            timeout_q  <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            hold_1_q   <= hold_1_d;
            hold_2_q   <= hold_2_d;
            stop_q     <= stop_d;
            pair_q     <= pair_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            tmo_q      <= tmo_d;
            timeout_q  <= timeout_d;
            finished_q <= finished_d;
        end
    end

`ifdef RETIRE_SCHED_ASSERT_EN
    // Invariants of the pairing protocol and the sticky status outputs.
    a_hold_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(hold_1_q && hold_2_q));
    a_quiet_idle_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == S_IDLE || state_q == S_DONE) |->
            (!run_1_o && !run_2_o && !enable_1_o && !enable_2_o));
    a_pair_b2b: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (pair_q && $past(pair_q)) |-> ($past(pair_done) && $past(pair_done, 2)));
    a_cnt_mono: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q >= $past(cnt_q));
    a_finished_sticky: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $past(finished_q) |-> finished_q);
`endif

endmodule

// File: tb/tb_retire_pair_scheduler.sv
// tb_retire_pair_scheduler: directed bench for retire_pair_scheduler.
// It builds the design with MAX_INSTR=4, DRAIN_CYCLES=3, TIMEOUT=10.
// Expected pair pulses are queued when the retires are driven.
// A negedge monitor pops and compares them against the pulses the design produces.
module tb_retire_pair_scheduler;
    localparam int CNT_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic             retire_1_i = 1'b0, retire_2_i = 1'b0;
    logic             fetch_1_i = 1'b0, fetch_2_i = 1'b0;
    logic [31:0]      instr_addr_1_i = '0, instr_addr_2_i = '0;
    logic [31:0]      end_addr_i = 32'hFFFF_FFFF;
    logic             run_1_o, run_2_o, enable_1_o, enable_2_o;
    logic             pair_retire_o, finished_o, timeout_o;
    logic [CNT_W-1:0] retire_cnt_o;

    retire_pair_scheduler #(
        .MAX_INSTR(4), .DRAIN_CYCLES(3), .TIMEOUT(10), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .retire_1_i(retire_1_i), .retire_2_i(retire_2_i),
        .fetch_1_i(fetch_1_i), .fetch_2_i(fetch_2_i),
        .instr_addr_1_i(instr_addr_1_i), .instr_addr_2_i(instr_addr_2_i),
        .end_addr_i(end_addr_i),
        .run_1_o(run_1_o), .run_2_o(run_2_o),
        .enable_1_o(enable_1_o), .enable_2_o(enable_2_o),
        .pair_retire_o(pair_retire_o), .retire_cnt_o(retire_cnt_o),
        .finished_o(finished_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [CNT_W-1:0] cnt;
    } pulse_t;

    pulse_t           sb_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_io(input string tag, input logic r1, input logic r2,
                             input logic e1, input logic e2, input logic fin, input logic tmo);
        check({tag, "/run_1"},    run_1_o,    r1);
        check({tag, "/run_2"},    run_2_o,    r2);
        check({tag, "/enable_1"}, enable_1_o, e1);
        check({tag, "/enable_2"}, enable_2_o, e2);
        check({tag, "/finished"}, finished_o, fin);
        check({tag, "/timeout"},  timeout_o,  tmo);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Retires driven in the current cycle produce a pulse in the next cycle.
    task automatic expect_pair();
        exp_cnt = exp_cnt + 1'b1;
        sb_q.push_back('{cyc: cyc + 1, cnt: exp_cnt});
    endtask

    task automatic do_reset(input string tag);
        rst_ni = 1'b0;
        start_i = 1'b0; retire_1_i = 1'b0; retire_2_i = 1'b0;
        fetch_1_i = 1'b0; fetch_2_i = 1'b0;
        instr_addr_1_i = '0; instr_addr_2_i = '0; end_addr_i = 32'hFFFF_FFFF;
        exp_cnt = '0;
        sb_q.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        expect_io(tag, 0, 0, 0, 0, 0, 0);
        check({tag, "/cnt"},  retire_cnt_o,  '0);
        check({tag, "/pair"}, pair_retire_o, 1'b0);
    endtask

    task automatic start_run(input string tag);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        expect_io(tag, 1, 1, 1, 1, 0, 0);
    endtask

    // Enter from the RUN cycle in which stop is set.
    // Expect three DRAIN cycles, then DONE.
    task automatic drain_to_done(input string tag);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_io({tag, "_drain"}, 1, 1, 0, 0, 0, 0);
        end
        tick();
        expect_io({tag, "_done"}, 0, 0, 0, 0, 1, 0);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    task automatic scenario_pairs(input string tag);
        start_run({tag, "_start"});
        for (int k = 0; k < 4; k++) begin
            retire_1_i = 1'b1; retire_2_i = 1'b1;
            expect_pair();
            tick();
            retire_1_i = 1'b0; retire_2_i = 1'b0;
            tick();
        end
        check({tag, "_cnt"}, retire_cnt_o, 8'd4);
        expect_io({tag, "_stop"}, 1, 1, 0, 0, 0, 0);
        drain_to_done(tag);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        expect_io({tag, "_done_sticky"}, 0, 0, 0, 0, 1, 0);
    endtask

    // Pulse monitor: each pair_retire_o pulse must match the next queued expectation.
    always @(negedge clk_i) begin
        pulse_t e;
        if (rst_ni && pair_retire_o) begin
            if (sb_q.size() == 0) begin
                check("pair_unexpected", pair_retire_o, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check("pair_cycle", cyc, e.cyc);
                check("pair_cnt", retire_cnt_o, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: four back-to-back pairs reach the budget, then drain, then finish.
        do_reset("s1_reset");
        scenario_pairs("s1");

        // 2: core 1 waits three cycles for core 2; a held retire is ignored.
        do_reset("s2_reset");
        start_run("s2_start");
        retire_1_i = 1'b1;
        tick();
        retire_1_i = 1'b0;
        expect_io("s2_hold_a", 0, 1, 1, 1, 0, 0);
        tick();
        retire_1_i = 1'b1;
        expect_io("s2_hold_b", 0, 1, 1, 1, 0, 0);
        tick();
        expect_io("s2_hold_c", 0, 1, 1, 1, 0, 0);
        retire_2_i = 1'b1;
        expect_pair();
        tick();
        retire_1_i = 1'b0; retire_2_i = 1'b0;
        expect_io("s2_paired", 1, 1, 1, 1, 0, 0);
        tick();
        expect_io("s2_after", 1, 1, 1, 1, 0, 0);
        check("s2_cnt", retire_cnt_o, 8'd1);
        check("s2_sb_empty", sb_q.size(), 0);

        // 3: core 2 never answers; timeout fires after ten hold cycles.
        do_reset("s3_reset");
        start_run("s3_start");
        retire_1_i = 1'b1;
        tick();
        retire_1_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            check("s3_hold_run_1", run_1_o, 1'b0);
            check("s3_hold_timeout", timeout_o, 1'b0);
            if (i < 10) tick();
        end
        tick();
        expect_io("s3_timeout", 0, 0, 0, 0, 1, 1);
        check("s3_cnt", retire_cnt_o, 8'd0);

        // 4: core 2 fetches at the end address after one pair; fetch stops.
        do_reset("s4_reset");
        end_addr_i = 32'h40;
        start_run("s4_start");
        retire_1_i = 1'b1; retire_2_i = 1'b1;
        expect_pair();
        tick();
        retire_1_i = 1'b0; retire_2_i = 1'b0;
        tick();
        fetch_1_i = 1'b1; instr_addr_1_i = 32'h3C;
        fetch_2_i = 1'b0; instr_addr_2_i = 32'h80;
        tick();
        expect_io("s4_below_end", 1, 1, 1, 1, 0, 0);
        fetch_1_i = 1'b0;
        fetch_2_i = 1'b1; instr_addr_2_i = 32'h40;
        tick();
        fetch_2_i = 1'b0;
        expect_io("s4_stop", 1, 1, 0, 0, 0, 0);
        check("s4_cnt", retire_cnt_o, 8'd1);
        drain_to_done("s4");

        // 5: drain expires while core 2 is held; core 1 completes the pair late.
        do_reset("s5_reset");
        end_addr_i = 32'h40;
        start_run("s5_start");
        retire_2_i = 1'b1;
        fetch_1_i = 1'b1; instr_addr_1_i = 32'h50;
        tick();
        retire_2_i = 1'b0; fetch_1_i = 1'b0;
        expect_io("s5_stop_hold", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_io("s5_drain_hold", 1, 0, 0, 0, 0, 0);
        end
        tick();
        expect_io("s5_wait_a", 1, 0, 0, 0, 0, 0);
        tick();
        expect_io("s5_wait_b", 1, 0, 0, 0, 0, 0);
        retire_1_i = 1'b1;
        expect_pair();
        tick();
        retire_1_i = 1'b0;
        expect_io("s5_paired", 1, 1, 0, 0, 0, 0);
        tick();
        expect_io("s5_done", 0, 0, 0, 0, 1, 0);
        check("s5_cnt", retire_cnt_o, 8'd1);
        check("s5_sb_empty", sb_q.size(), 0);

        // 6: reset asserted mid-RUN with core 1 held; then a clean rerun of scenario 1.
        do_reset("s6_reset");
        start_run("s6_start");
        retire_1_i = 1'b1; retire_2_i = 1'b1;
        expect_pair();
        tick();
        retire_2_i = 1'b0;
        tick();
        retire_1_i = 1'b0;
        check("s6_held_run_1", run_1_o, 1'b0);
        check("s6_held_cnt", retire_cnt_o, 8'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        expect_io("s6_async_reset", 0, 0, 0, 0, 0, 0);
        check("s6_async_cnt", retire_cnt_o, 8'd0);
        check("s6_async_pair", pair_retire_o, 1'b0);
        do_reset("s6_rereset");
        scenario_pairs("s6_rerun");

        check("final_sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
